// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio output stage.
//   SAMPLE_W  : width of one audio sample
//   PWM_STEPS : PWM steps per output period, one sample per period
//   sample_t  : unsigned sample, 0 = minimum level, 255 = maximum level
//   PWM_LAST  : last step of a period; a tick on this step is the load point
package audio_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int PWM_STEPS = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t PWM_LAST = sample_t'(PWM_STEPS - 1);

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO sitting between the upstream sample source and the
// PWM loader. Push and pop may occur in the same cycle.
// Ports:
//   CLK     : system clock, rising edge
//   RST     : synchronous active-high reset, discards all contents
//   push_i  : write data_i (ignored while full)
//   data_i  : sample to write
//   pop_i   : drop the head entry (ignored while empty)
//   data_o  : current head entry, valid while not empty
//   full_o  : no free entries
//   empty_o : no stored entries
//   count_o : current occupancy, 0..DEPTH
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push_i,
    input  sample_t                  data_i,
    input  logic                     pop_i,
    output sample_t                  data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

    sample_t           mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pwm_audio_dac.sv
// Streaming 8-bit PWM audio output stage. Samples arrive over valid/ready,
// are buffered in sample_fifo, and one sample is played per 256-step PWM
// period on audio_out. An empty FIFO at the load point holds the last sample
// and pulses underrun.
// Ports:
//   CLK           : system clock, rising edge
//   RST           : synchronous active-high reset
//   enable        : run PWM; low idles the output (FIFO still accepts)
//   s_data        : unsigned sample
//   s_valid       : s_data valid
//   s_ready       : FIFO not full; transfer on s_valid && s_ready
//   audio_out     : registered PWM output
//   sample_strobe : one-cycle pulse when a sample is popped into the player
//   underrun      : one-cycle pulse when a load is due but the FIFO is empty
//   fill          : current FIFO occupancy
module pwm_audio_dac
    import audio_pkg::*;
#(
    parameter int DIV        = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          audio_out,
    output logic                          sample_strobe,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int              DW       = $clog2(DIV);
    localparam int              DIV_M1   = DIV - 1;
    localparam logic [DW-1:0]   DIV_LAST = DIV_M1[DW-1:0];

    logic [DW-1:0] div_cnt_q,   div_cnt_d;
    sample_t       pwm_cnt_q,   pwm_cnt_d;
    sample_t       cur_q,       cur_d;
    logic          audio_out_q, audio_out_d;

    sample_t       fifo_head;
    logic          fifo_full, fifo_empty;
    logic          tick, load_pt, pop;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (s_valid),
        .data_i  (s_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill)
    );

    // Gating with RST keeps the combinational pulses quiet while in reset.
    assign tick          = enable && !RST && (div_cnt_q == DIV_LAST);
    assign load_pt       = tick && (pwm_cnt_q == PWM_LAST);
    assign pop           = load_pt && !fifo_empty;
    assign sample_strobe = pop;
    assign underrun      = load_pt && fifo_empty;
    assign s_ready       = !fifo_full;
    assign audio_out     = audio_out_q;

    // Idle parks pwm_cnt on the last step so the first tick after enable
    // rises is a load point.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        cur_d       = cur_q;
        audio_out_d = 1'b0;
        if (enable) begin
            div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (pop)  cur_d     = fifo_head;
            audio_out_d = (cur_q > pwm_cnt_q);
        end else begin
            div_cnt_d = '0;
            pwm_cnt_d = PWM_LAST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt_q   <= '0;
            pwm_cnt_q   <= PWM_LAST;
            cur_q       <= '0;
            audio_out_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            cur_q       <= cur_d;
            audio_out_q <= audio_out_d;
        end
    end

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Bench for pwm_audio_dac. Accepted samples go into a scoreboard queue; each
// load point pops it, and the audio_out high count over the following full
// period is compared with the popped (or held) sample times DIV.
module tb_pwm_audio_dac;
    import audio_pkg::*;

    localparam int DIV        = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PERIOD     = PWM_STEPS * DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enable = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, audio_out, sample_strobe, underrun;
    logic [2:0] fill;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int   model_cur  = 0;
    int   cur_win    = 0;
    int   hi_cnt     = 0;
    int   win_len    = 0;
    logic win_valid  = 1'b0;
    logic close_pend = 1'b0;
    logic en_prev    = 1'b0;
    int   n_strobe   = 0;
    int   n_under    = 0;

    pwm_audio_dac #(
        .DIV        (DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .enable        (enable),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .audio_out     (audio_out),
        .sample_strobe (sample_strobe),
        .underrun      (underrun),
        .fill          (fill)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Holds s_valid until the sample is taken; leaves s_valid high on return.
    task automatic push_one(input logic [7:0] v);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        s_data  = v;
        s_valid = 1'b1;
        while (!acc && t < 4 * PERIOD) begin
            @(negedge CLK);
            t++;
            acc = s_ready;
            @(posedge CLK);
            #1;
        end
        if (!acc) check_val("push_timeout", 32'(s_ready), 1);
    endtask

    task automatic wait_event(input int max_cyc, output int n, output logic was_strobe);
        logic done;
        n = 0;
        done = 1'b0;
        was_strobe = 1'b0;
        while (!done && n < max_cyc) begin
            @(negedge CLK);
            n++;
            if (sample_strobe || underrun) begin
                was_strobe = sample_strobe;
                done = 1'b1;
            end
        end
        if (!done) check_val("event_timeout", 32'(sample_strobe | underrun), 1);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            check_val("fill", 32'(fill), exp_q.size());
            check_val("s_ready", 32'(s_ready), 32'(exp_q.size() < FIFO_DEPTH));
            check_val("pulse_excl", 32'(sample_strobe & underrun), 0);
            if (!en_prev) check_val("audio_idle", 32'(audio_out), 0);
            if (RST) begin
                exp_q.delete();
                model_cur  = 0;
                cur_win    = 0;
                hi_cnt     = 0;
                win_len    = 0;
                win_valid  = 1'b0;
                close_pend = 1'b0;
            end else begin
                hi_cnt  += int'(audio_out);
                win_len++;
                if (close_pend) begin
                    if (win_valid) begin
                        check_val("duty", hi_cnt, cur_win * DIV);
                        check_val("period_len", win_len, PERIOD);
                    end
                    hi_cnt     = 0;
                    win_len    = 0;
                    close_pend = 1'b0;
                    win_valid  = 1'b1;
                    cur_win    = model_cur;
                end
                if (!enable) begin
                    win_valid = 1'b0;
                    check_val("idle_pulse", 32'(sample_strobe | underrun), 0);
                end
                if (sample_strobe) begin
                    n_strobe++;
                    if (exp_q.size() == 0) check_val("strobe_on_empty", 32'(sample_strobe), 0);
                    else model_cur = int'(exp_q.pop_front());
                    close_pend = 1'b1;
                end
                if (underrun) begin
                    n_under++;
                    check_val("underrun_q_empty", exp_q.size(), 0);
                    close_pend = 1'b1;
                end
                if (s_valid && s_ready) exp_q.push_back(s_data);
            end
            en_prev = enable;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic s;
        int   u0;

        // Power-on reset
        cyc(3);
        RST = 1'b0;
        check_val("rst_s_ready", 32'(s_ready), 1);
        check_val("rst_fill", 32'(fill), 0);
        check_val("rst_audio", 32'(audio_out), 0);

        // Reset in the middle of a running period with samples buffered
        push_one(8'h80);
        s_valid = 1'b0;
        enable  = 1'b1;
        cyc(DIV * 300);
        push_one(8'h11);
        s_valid = 1'b0;
        RST = 1'b1;
        cyc(2);
        check_val("mrst_s_ready", 32'(s_ready), 1);
        check_val("mrst_fill", 32'(fill), 0);
        check_val("mrst_audio", 32'(audio_out), 0);
        check_val("mrst_strobe", 32'(sample_strobe), 0);
        check_val("mrst_underrun", 32'(underrun), 0);
        RST    = 1'b0;
        enable = 1'b0;

        // Duty: 0x40, 0x00, 0xFF, then held 0xFF across two underruns
        push_one(8'h40);
        push_one(8'h00);
        push_one(8'hFF);
        s_valid = 1'b0;
        enable  = 1'b1;
        wait_event(PERIOD + 4, n, s);
        check_val("first_load_lat", n, DIV);
        check_val("first_load_strobe", 32'(s), 1);
        for (int i = 0; i < 4; i++) begin
            wait_event(PERIOD + 4, n, s);
            check_val("duty_ph_len", n, PERIOD);
            check_val("duty_ph_kind", 32'(s), 32'(i < 2));
        end
        cyc(2);
        enable = 1'b0;

        // Backpressure: 0x01..0x05 with valid held, PWM idle
        fork
            begin
                for (int v = 1; v <= 5; v++) push_one(8'(v));
                s_valid = 1'b0;
            end
            begin
                cyc(12);
                check_val("bp_fill", 32'(fill), 4);
                check_val("bp_s_ready", 32'(s_ready), 0);
                enable = 1'b1;
                wait_event(PERIOD + 4, n, s);
                check_val("bp_first_lat", n, DIV);
                check_val("bp_first_kind", 32'(s), 1);
                for (int i = 0; i < 5; i++) begin
                    wait_event(PERIOD + 4, n, s);
                    check_val("bp_len", n, PERIOD);
                    check_val("bp_kind", 32'(s), 32'(i < 4));
                end
            end
        join
        cyc(2);
        enable = 1'b0;

        // Underrun holds the last sample
        u0 = n_under;
        push_one(8'h80);
        s_valid = 1'b0;
        enable  = 1'b1;
        wait_event(PERIOD + 4, n, s);
        check_val("ur_load_kind", 32'(s), 1);
        wait_event(PERIOD + 4, n, s);
        check_val("ur_second_kind", 32'(s), 0);
        wait_event(PERIOD + 4, n, s);
        check_val("ur_third_kind", 32'(s), 0);
        cyc(2);
        check_val("ur_count", n_under - u0, 2);
        enable = 1'b0;

        // Push and pop on the same load point with two entries buffered
        push_one(8'h20);
        push_one(8'h30);
        s_valid = 1'b0;
        check_val("sp_fill_pre", 32'(fill), 2);
        enable = 1'b1;
        cyc(DIV - 1);
        s_data  = 8'h50;
        s_valid = 1'b1;
        @(negedge CLK);
        check_val("sp_strobe", 32'(sample_strobe), 1);
        check_val("sp_fill_at", 32'(fill), 2);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        @(negedge CLK);
        check_val("sp_fill_post", 32'(fill), 2);
        wait_event(PERIOD + 4, n, s);
        check_val("sp_next_len", n, PERIOD - 1);
        check_val("sp_next_kind", 32'(s), 1);
        wait_event(PERIOD + 4, n, s);
        check_val("sp_third_kind", 32'(s), 1);
        wait_event(PERIOD + 4, n, s);
        check_val("sp_drain_kind", 32'(s), 0);
        cyc(2);
        enable = 1'b0;

        // Push into an empty FIFO on the load-point cycle: no bypass
        cyc(1);
        enable = 1'b1;
        cyc(DIV - 1);
        s_data  = 8'h60;
        s_valid = 1'b1;
        @(negedge CLK);
        check_val("pe_underrun", 32'(underrun), 1);
        check_val("pe_strobe", 32'(sample_strobe), 0);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        @(negedge CLK);
        check_val("pe_fill", 32'(fill), 1);
        wait_event(PERIOD + 4, n, s);
        check_val("pe_load_len", n, PERIOD - 1);
        check_val("pe_load_kind", 32'(s), 1);
        wait_event(PERIOD + 4, n, s);
        check_val("pe_after_kind", 32'(s), 0);
        cyc(2);
        enable = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_audio_dac.md
# pwm_audio_dac

Streaming 8-bit PWM audio output stage. Accepts unsigned 8-bit samples from an upstream sample source (memory reader, SD/flash streamer) over a valid/ready handshake, buffers them in a small FIFO, and emits one sample per 256-step PWM period on a single-bit `audio_out` pin driving the board's RC filter. Underruns are flagged and the last sample is held.

## Interface
- `DIV`, 26: clocks per PWM step (step tick every `DIV` clocks); must be ≥ 2
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥ 2
- `CLK`  in  1  system clock; all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `enable`  in  1  run PWM; low = idle (FIFO still accepts)
- `s_data`  in  8  unsigned sample, 0 = min, 255 = max
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  FIFO not full; transfer when `s_valid && s_ready`
- `audio_out`  out  1  registered PWM output
- `sample_strobe`  out  1  one-cycle pulse when a sample is popped and loaded
- `underrun`  out  1  one-cycle pulse when a load is due and FIFO is empty
- `fill`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset: FIFO empty, `fill`=0, `s_ready`=1, `audio_out`=0, `sample_strobe`=0, `underrun`=0, `cur`=0, `div_cnt`=0, `pwm_cnt`=255.
- `s_ready` = !full, combinational from registered count only (no dependence on `s_valid`).
- `div_cnt` counts 0..DIV-1 while `enable`; `tick` asserted when `div_cnt`==DIV-1 (wraps to 0).
- On `tick`: `pwm_cnt` <= `pwm_cnt`+1 (8-bit wrap 255→0).
- Load point: `tick` with `pwm_cnt`==255. If FIFO non-empty: pop head into `cur`, pulse `sample_strobe`. If empty: `cur` unchanged (hold last), pulse `underrun`.
- `audio_out` <= (`cur` > `pwm_cnt`) every cycle while `enable`. Duty = `cur`/256: 0 → always low, 255 → high 255 of 256 steps.
- `enable` low: `div_cnt` held 0, `pwm_cnt` held 255, `audio_out` <= 0, no strobes; `cur` retained. First `tick` after `enable` rises is therefore a load point.
- Push and pop in same cycle: both performed, `fill` unchanged.
- Push into empty FIFO on a load-point cycle: no bypass; load sees empty → `underrun`, pushed sample stays in FIFO.
- `RST` mid-period: all state returns to reset values next edge; FIFO contents discarded.

## Timing
- Step = `DIV` clocks; PWM period = 256·`DIV` clocks (6656 at default); one sample per period.
- `audio_out` lags `cur`/`pwm_cnt` by one clock (registered compare).
- Sample accepted on edge N appears in `fill` at N+1; earliest load at next load point after N.
- From `enable` rise with FIFO holding a sample: `sample_strobe` at clock `DIV` after rise; `audio_out` reflects new sample one clock later.
- `sample_strobe` and `underrun` mutually exclusive, one cycle each, coincident with load-point `tick`.

## Structure
- Shared package `audio_pkg`: `SAMPLE_W`=8, `PWM_STEPS`=256, sample type `sample_t` (8-bit unsigned).
- One sub-module: `sample_fifo` (synchronous FIFO, width `SAMPLE_W`, depth `FIFO_DEPTH`, push/pop/full/empty/count, sync active-high reset). Counters and compare live in the top.

## Test plan
- Reset: assert `RST` 2 cycles mid-operation → all outputs at reset values, `s_ready`=1, `fill`=0 next cycle.
- Duty check: push 0x40, `enable`=1 → `sample_strobe` at clock 26; over next 6656 clocks `audio_out` high exactly 64·26=1664 clocks; 0x00 → 0 high, 0xFF → 6630 high.
- Backpressure: hold `s_valid`=1 with `enable`=0, push 0x01..0x05 → 4 accepted, `s_ready`=0, `fill`=4; enable → loaded order 0x01..0x04, 0x05 accepted after first pop.
- Underrun: push one sample 0x80, run 2 periods → second load point pulses `underrun`, `cur` stays 0x80, duty unchanged.
- Simultaneous push/pop at load point with `fill`=2 → `fill` stays 2, popped value is older head.
- Push into empty FIFO on load-point cycle → `underrun` pulses, `fill`=1, sample loaded at following load point.
